data_mem_resp: RTL

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_resp.sv
// Word-organised data memory answering RV32I loads/stores over a valid/ready request and a valid/ready response.
// Latency: rsp_valid is first seen LATENCY+1 rising edges after the accept edge, counting that edge.
// Backpressure: one request at a time; req_ready is low from accept until the response handshake completes.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready, req_we, req_f3, req_addr, req_wdata : request channel
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err                 : response channel
module data_mem_resp #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  // Storage is deliberately outside the reset domain.
  logic [31:0] mem [DEPTH_WORDS];

  logic          op_we;
  logic [2:0]    op_f3;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic          op_err;
  logic          go_resp;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_val;
  logic [3:0]    st_be;
  logic [31:0]   st_data;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // With LATENCY=0 the edge that accepts the request is also the edge that
  // enters RESP, so the operation must be decoded from the live request
  // rather than the (not yet loaded) registered copy.
  always_comb begin
    if (state == IDLE) begin
      op_we    = req_we;
      op_f3    = req_f3;
      op_addr  = req_addr;
      op_wdata = req_wdata;
    end else begin
      op_we    = r_we;
      op_f3    = r_f3;
      op_addr  = r_addr;
      op_wdata = r_wdata;
    end
  end

  assign idx  = op_addr[AW+1:2];
  assign word = mem[idx];

  always_comb begin
    op_err = 1'b0;
    if (op_we) begin
      case (op_f3)
        3'b000:  op_err = 1'b0;
        3'b001:  op_err = op_addr[0];
        3'b010:  op_err = (op_addr[1:0] != 2'b00);
        default: op_err = 1'b1;
      endcase
    end else begin
      case (op_f3)
        3'b000, 3'b100: op_err = 1'b0;
        3'b001, 3'b101: op_err = op_addr[0];
        3'b010:         op_err = (op_addr[1:0] != 2'b00);
        default:        op_err = 1'b1;
      endcase
    end
    if (op_addr[31:2] >= 30'(DEPTH_WORDS)) begin
      op_err = 1'b1;
    end
  end

  always_comb begin
    ld_byte = word[{op_addr[1:0], 3'b000} +: 8];
    ld_half = op_addr[1] ? word[31:16] : word[15:0];
    case (op_f3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'h0, ld_byte};
      3'b101:  ld_val = {16'h0, ld_half};
      default: ld_val = word;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the lanes.
  always_comb begin
    case (op_f3)
      3'b000: begin
        st_be   = 4'b0001 << op_addr[1:0];
        st_data = {4{op_wdata[7:0]}};
      end
      3'b001: begin
        st_be   = op_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{op_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = op_wdata;
      end
    endcase
  end

  // Single-cycle event: the edge that moves the FSM into RESP.
  assign go_resp = ((state == IDLE) && req_valid && (LATENCY == 0)) ||
                   ((state == WAIT) && (cnt == 4'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      r_we      <= 1'b0;
      r_f3      <= 3'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_f3    <= req_f3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (LATENCY == 0) begin
              state <= RESP;
              cnt   <= 4'd0;
            end else begin
              state <= WAIT;
              cnt   <= LAT4;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase

      if (go_resp) begin
        rsp_err   <= op_err;
        rsp_rdata <= (op_err || op_we) ? 32'd0 : ld_val;
      end
    end
  end

  // Reset cannot produce go_resp from WAIT (state is forced to IDLE), so an
  // abandoned store never reaches this write.
  always_ff @(posedge clk) begin
    if (go_resp && op_we && !op_err) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) begin
          mem[idx][8*i +: 8] <= st_data[8*i +: 8];
        end
      end
    end
  end

endmodule
